// File: rtl/alu_pkg.sv
// Shared ALU definitions for the ID-stage control decoder and the EX stage:
// datapath width, ALU control code width and the code constants.
package alu_pkg;

  // Only 32 is supported: lui relies on a fixed 16-bit shift.
  localparam int DATA_W = 32;
  localparam int ALUC_W = 5;

  typedef logic [ALUC_W-1:0] aluc_t;

  localparam aluc_t ALU_ADD  = 5'd0;
  localparam aluc_t ALU_ADDU = 5'd1;
  localparam aluc_t ALU_SUB  = 5'd2;
  localparam aluc_t ALU_SUBU = 5'd3;
  localparam aluc_t ALU_AND  = 5'd4;
  localparam aluc_t ALU_OR   = 5'd5;
  localparam aluc_t ALU_XOR  = 5'd6;
  localparam aluc_t ALU_NOR  = 5'd7;
  localparam aluc_t ALU_SLT  = 5'd8;
  localparam aluc_t ALU_SLTU = 5'd9;
  localparam aluc_t ALU_SLL  = 5'd10;
  localparam aluc_t ALU_SRL  = 5'd11;
  localparam aluc_t ALU_SRA  = 5'd12;
  localparam aluc_t ALU_SLC  = 5'd13;
  localparam aluc_t ALU_LUI  = 5'd14;
  // Codes 15..31 are reserved and produce a zero result.

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the EX stage.
// Build option: EX_OVF_TRAP_EN enables the signed-overflow detector for
// add/sub; without it o_ovf is a constant 0 and no comparator is built.
module alu_core
  import alu_pkg::*;
(
  input  logic [ALUC_W-1:0] i_aluc,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_ovf
);

  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_rot;

  // Shift amount always comes from the low five bits of operand A.
  assign w_shamt = i_a[4:0];
  assign w_sum   = i_a + i_b;
  assign w_diff  = i_a - i_b;
  // Rotate left; a zero amount makes the right shift 32, which yields 0.
  assign w_rot   = (i_b << w_shamt) | (i_b >> (6'd32 - {1'b0, w_shamt}));

  // Result select; reserved codes fall through to zero.
  always_comb begin
    o_result = '0;
    case (i_aluc)
      ALU_ADD,
      ALU_ADDU: o_result = w_sum;
      ALU_SUB,
      ALU_SUBU: o_result = w_diff;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result[0] = ($signed(i_a) < $signed(i_b));
      ALU_SLTU: o_result[0] = (i_a < i_b);
      ALU_SLL:  o_result = i_b << w_shamt;
      ALU_SRL:  o_result = i_b >> w_shamt;
      ALU_SRA:  o_result = $signed(i_b) >>> w_shamt;
      ALU_SLC:  o_result = w_rot;
      ALU_LUI:  o_result = {i_b[15:0], 16'h0000};
      default:  o_result = '0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  logic w_add_ovf;
  logic w_sub_ovf;

  // Overflow: add with equal operand signs, or sub with differing signs,
  // whose result sign differs from operand A.
  assign w_add_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1]  != i_a[DATA_W-1]);
  assign w_sub_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);
  assign o_ovf     = ((i_aluc == ALU_ADD) && w_add_ovf) || ((i_aluc == ALU_SUB) && w_sub_ovf);
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, EX/MEM register.
// Two-cycle latency from input acceptance to out_valid, one op per cycle.
// Build option: EX_OVF_TRAP_EN turns signed overflow on add/sub into a trap
// (out_ovf = 1, out_wen forced to 0); otherwise out_ovf is tied to 0.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its data until that edge; ready
// may depend combinationally on the consumer's ready (in_ready follows
// out_ready) but never on valid. flush kills whatever stage 1 loads or holds.
module ex_stage
  import alu_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ALUC_W-1:0] in_aluc,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [RA_W-1:0]   in_wreg,
  input  logic              in_wen,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RA_W-1:0]   out_wreg,
  output logic              out_wen,
  output logic              out_ovf
);

  // Stage 1 (ID/EX)
  logic              r_s1_valid;
  logic [ALUC_W-1:0] r_s1_aluc;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [RA_W-1:0]   r_s1_wreg;
  logic              r_s1_wen;

  // Stage 2 (EX/MEM)
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic [RA_W-1:0]   r_out_wreg;
  logic              r_out_wen;

  logic              w_adv2;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_ovf;

  assign w_adv2   = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_adv2;

  alu_core u_alu (
    .i_aluc   (r_s1_aluc),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .o_result (w_alu_result),
    .o_ovf    (w_alu_ovf)
  );

  // Stage 1: load on in_ready; flush kills the loaded or held instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_aluc  <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_wreg  <= '0;
      r_s1_wen   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid && !flush;
      r_s1_aluc  <= in_aluc;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_wreg  <= in_wreg;
      r_s1_wen   <= in_wen;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: capture the ALU result whenever the output slot frees up.
  // w_alu_ovf is constant 0 when the trap is not built, so wen passes through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_wreg   <= '0;
      r_out_wen    <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid  <= r_s1_valid;
      r_out_result <= w_alu_result;
      r_out_wreg   <= r_s1_wreg;
      r_out_wen    <= r_s1_wen && !w_alu_ovf;
    end
  end

`ifdef EX_OVF_TRAP_EN
  logic r_out_ovf;

  // Overflow flag travels with the result it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_ovf <= 1'b0;
    end else if (w_adv2) begin
      r_out_ovf <= r_s1_valid && w_alu_ovf;
    end
  end

  assign out_ovf = r_out_ovf;
`else
  assign out_ovf = 1'b0;
`endif

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_wreg   = r_out_wreg;
  assign out_wen    = r_out_wen;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline; consumes the 5-bit ALU control code produced by the ALU-control decoder in ID, together with the operands and destination info. Holds an ID/EX input register and an EX/MEM output register, computes the ALU result between them, and passes it downstream under a valid/ready handshake with stall back-pressure and flush. Fixed latency of two cycles from input acceptance to output valid when not stalled.

## Interface
- DATA_W, 32, datapath width; only 32 is supported because lui uses a fixed shift of 16.
- RA_W, 5, register-address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage 1 can accept this cycle.
- in_aluc  in  5  ALU control code, encoding below.
- in_a  in  DATA_W  operand A (rs, or shamt zero-extended for shifts).
- in_b  in  DATA_W  operand B (rt or extended immediate).
- in_wreg  in  RA_W  destination register.
- in_wen  in  1  register write enable.
- flush  in  1  kill the instruction in stage 1.
- out_valid  out  1  EX/MEM register holds a valid result.
- out_ready  in  1  downstream (MEM) accepts this cycle.
- out_result  out  DATA_W  ALU result.
- out_wreg  out  RA_W  destination register.
- out_wen  out  1  write enable, after the overflow kill.
- out_ovf  out  1  signed-overflow trap flag.

## Operation
- ALU codes:
  - 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor.
  - 8 slt (signed), 9 sltu (unsigned); result is 0 or 1, zero-extended.
  - 10 sll, 11 srl, 12 sra: operand B shifted by A[4:0]; upper bits of A ignored.
  - 13 slc: rotate B left by A[4:0].
  - 14 lui: B[15:0] followed by 16 zero bits.
  - 15–31 reserved: result 0, no overflow.
- Arithmetic is modulo 2^32. Signed overflow is detected only for codes 0 and 2: operand signs are equal (add) or differ (sub), and the result sign differs from A.
- Stage 1 (ID/EX) fields: s1_valid, aluc, a, b, wreg, wen.
- Stage 2 (EX/MEM) fields: out_* registers.
- Stage 2 advance: adv2 = !out_valid || out_ready.
- Stage 1 advance: in_ready = !s1_valid || adv2.
- On adv2, stage 2 loads the ALU result and s1_valid. A bubble loads out_valid = 0, and the other fields are don't-care.
- On in_ready, stage 1 loads the inputs, with s1_valid = in_valid && !flush.
- flush with in_ready = 0: s1_valid is cleared and the held instruction is lost. Stage 2 is never affected by flush.
- flush together with in_valid and in_ready: the input is consumed and discarded; upstream treats it as transferred.
- Reset (asynchronous, any time, including mid-stall): s1_valid = 0, out_valid = 0, out_result = 0, out_wreg = 0, out_wen = 0, out_ovf = 0. in_ready = 1 on the first cycle after release.

## Timing
- Input accepted at edge N → result on out_* after edge N+1, provided out_ready was high or out_valid was low at N+1.
- Throughput is one instruction per cycle with out_ready held high.
- out_ready low holds out_* stable and keeps stage 1 full. in_ready drops only once both stages are full and out_ready is low.
- in_ready and adv2 are combinational from out_ready. There is no combinational path from in_* to out_*.

## Configuration
- EX_OVF_TRAP_EN defined:
  - Overflow on code 0 or 2 sets out_ovf = 1 with out_valid and forces out_wen = 0.
  - out_result still carries the wrapped sum.
- EX_OVF_TRAP_EN undefined:
  - out_ovf is tied to 0, and out_wen = the stage-1 wen unmodified.
  - The overflow comparator is not synthesised.

## Structure
- Shared package alu_pkg holds the ALU code constants (ALU_ADD … ALU_LUI), the code width, and DATA_W. The control decoder uses the same package.
- One combinational sub-module, alu_core (aluc, a, b → result, ovf).
- ex_stage holds only the two register stages and the handshake logic.

## Test plan
- Add overflow: add 0x7FFFFFFF + 1, out_ready = 1.
  - With EX_OVF_TRAP_EN: out_result = 0x80000000, out_ovf = 1, out_wen = 0, two cycles after acceptance.
  - Without the macro: out_ovf = 0, out_wen = 1.
- Compare and shifts:
  - slt −1 vs 1 → 1; sltu 0xFFFFFFFF vs 1 → 0.
  - sra B = 0x80000000, A = 31 → 0xFFFFFFFF.
  - slc B = 0x80000001, A = 1 → 0x00000003.
  - lui B = 0x1234 → 0x12340000.
- Back-pressure:
  - Stream 4 addu ops with out_ready low from cycle 2 for 3 cycles.
  - in_ready falls once both stages are full, and out_* are held stable.
  - All 4 results emerge in order with none lost or duplicated.
- Flush:
  - Assert flush while stage 1 holds an instruction and stage 2 is stalled. That instruction never appears on the output; the stage 2 result is still delivered.
  - Flush together with in_valid: the input is dropped.
- Reset: assert rst_n low asynchronously mid-stream with both stages valid. out_valid and all out_* go to 0 immediately, before the next edge, and in_ready = 1 after release.
- Reserved code 20 → out_result = 0, out_ovf = 0, out_wen passed through.
